rot_dma_engine: RTL
===================

# rot_dma_engine

Request-side responder for the rotation address generator: accepts the address/size/direction/beat-count requests that `core_set` issues and answers with `O_DMA_READY`. Each accepted request runs as an AHB-Lite master burst on the system bus. Read bursts fill an internal 32-word pixel FIFO; write bursts drain it. The block sits between `core_set` and the AHB interconnect, in the `I_HCLK` domain.

## Interface
- `FIFO_DEPTH`, 32: pixel buffer depth in 32-bit words; power of two, at least 32.
- `I_HCLK`  in  1  system clock; all logic on the rising edge.
- `I_HRESET_N`  in  1  synchronous, active-low reset.
- `I_START`  in  1  frame-start pulse. While IDLE it flushes the FIFO and clears `O_ERROR`. Ignored otherwise.
- `I_BUSY`  in  1  request valid, driven from core_set `O_BUSY`.
- `I_ADDR`  in  32  burst start address.
- `I_SIZE`  in  3  HSIZE encoding. Legal values are 0, 1 and 2.
- `I_WRITE`  in  1  1 = write burst (drains the FIFO); 0 = read burst (fills the FIFO).
- `I_COUNT`  in  5  beats minus one, giving 1 to 32 beats.
- `O_DMA_READY`  out  1  request may be accepted this cycle.
- `O_ERROR`  out  1  sticky error flag.
- `O_LEVEL`  out  6  FIFO occupancy, 0 to 32.
- `O_HADDR`  out  32, `O_HTRANS`  out  2, `O_HWRITE`  out  1, `O_HSIZE`  out  3, `O_HBURST`  out  3, `O_HWDATA`  out  32: AHB-Lite master outputs.
- `I_HRDATA`  in  32, `I_HREADY`  in  1, `I_HRESP`  in  1: AHB-Lite master inputs.

## Operation
- **States:**
  - IDLE: `O_DMA_READY` may be high.
  - ADDR: first address phase.
  - BURST: address phase overlapped with the previous beat's data phase.
  - LAST: data phase only.
  - ERR: two-cycle error response.
- **Acceptance:**
  - A request is accepted on an edge where `I_BUSY & O_DMA_READY` is high.
  - On acceptance the block latches addr, size, write and beats = `I_COUNT`+1.
- **Ready conditions:** `O_DMA_READY` = IDLE & legal `I_SIZE` & resources available.
  - Read: free space ≥ beats.
  - Write: `O_LEVEL` ≥ beats.
  - `O_DMA_READY` is combinational on the `I_*` request fields, so it stays low until the condition holds and never overflows or underflows the FIFO.
- **Illegal size:** `I_BUSY` with `I_SIZE` > 2 while IDLE:
  - the request is consumed without any bus activity;
  - `O_ERROR` sets;
  - `O_DMA_READY` pulses high for that one cycle.
- **Burst encoding:**
  - `O_HTRANS` is NONSEQ (2'b10) for the first beat and SEQ (2'b11) for later beats.
  - `O_HBURST` is SINGLE (3'b000) for 1 beat and INCR (3'b001) for more than 1 beat.
- **Addressing:**
  - Beat k address = start + k·(1<<size), modulo 2^32.
  - `O_HSIZE` = latched size.
- **Read data:** `I_HRDATA` is pushed into the FIFO on every data-phase cycle with `I_HREADY`=1, stored as a full word with no lane extraction.
- **Write data:** `O_HWDATA` = FIFO head during each data phase; the head is popped on data-phase `I_HREADY`=1.
- **Error handling:** `I_HRESP`=1 with `I_HREADY`=0 in a data phase:
  1. the block drives `O_HTRANS`=IDLE on the next cycle;
  2. it completes the second error cycle;
  3. it abandons the remaining beats;
  4. `O_ERROR` sets;
  5. it returns to IDLE.
  - FIFO entries already moved remain moved.
- **Reset:**
  - Reset in any state returns to IDLE on that edge.
  - Reset empties the FIFO and clears `O_ERROR`.

## Timing
- **Reset values:**
  - `O_HTRANS`=2'b00; `O_HADDR`, `O_HWRITE`, `O_HSIZE`, `O_HBURST`, `O_HWDATA` = 0.
  - `O_DMA_READY`=0, `O_ERROR`=0, `O_LEVEL`=0.
- All AHB outputs are registered.
- **Zero-wait-state sequence** (acceptance at edge N):
  - edge N+1: NONSEQ is on the bus (first address phase).
  - beat k address phase: cycle N+1+k.
  - final data phase: cycle N+beats+1.
  - `O_DMA_READY` can be high again from cycle N+beats+2.
- **Wait states:** `I_HREADY`=0 holds the address, control and `O_HWDATA` unchanged, and extends every phase by one cycle per wait.
- A push and a pop never occur in the same cycle, because bursts are single-direction.
- An `I_START` that coincides with acceptance is ignored; acceptance wins.

## Configuration
- `ROT_DMA_1KB_SPLIT_EN`
  - **Defined:** a beat whose address crosses a 1 KB boundary (addr[9:0] wraps) is issued as NONSEQ with HBURST=INCR, restarting the burst per the AHB 1 KB rule. Beat count and data order are unchanged.
  - **Undefined:** every non-first beat is SEQ regardless of address.

## Test plan
- Reset, then read: `I_ADDR`=0x100, size 2, `I_COUNT`=7.
  - Expect NONSEQ at 0x100, then SEQ at 0x104 through 0x11C, HBURST=INCR.
  - Expect `O_LEVEL`=8 and ready again at N+10.
- Write 8 beats at 0x200 after that read: `O_HWDATA` replays the 8 read words in order, and `O_LEVEL` ends at 0.
- Write request with `O_LEVEL`=3 and `I_COUNT`=7: `O_DMA_READY` stays 0 and the bus stays IDLE.
- Read with `I_HREADY` low for 2 cycles at beat 3: address and control are held, no extra push occurs, and the final level is correct.
- `I_HRESP` error on beat 2 of 4: HTRANS goes IDLE on the next cycle, `O_ERROR`=1, `O_LEVEL`=2 (beats 0 and 1). A following `I_START` while IDLE clears `O_ERROR` and the level.
- Read at 0x3F8, size 2, 4 beats:
  - with `ROT_DMA_1KB_SPLIT_EN`: NONSEQ at 0x3F8 and at 0x400;
  - without it: only the first beat is NONSEQ.

Source files
------------

// File: rtl/rot_dma_engine.sv
// rot_dma_engine: turns core_set burst requests into AHB-Lite master bursts through a pixel FIFO.
// Build option ROT_DMA_1KB_SPLIT_EN re-issues NONSEQ on any beat that crosses a 1 KB boundary.
module rot_dma_engine #(
    parameter int FIFO_DEPTH = 32
) (
    input  logic                        I_HCLK,
    input  logic                        I_HRESET_N,
    input  logic                        I_START,
    input  logic                        I_BUSY,
    input  logic [31:0]                 I_ADDR,
    input  logic [2:0]                  I_SIZE,
    input  logic                        I_WRITE,
    input  logic [4:0]                  I_COUNT,
    output logic                        O_DMA_READY,
    output logic                        O_ERROR,
    output logic [$clog2(FIFO_DEPTH):0] O_LEVEL,
    output logic [31:0]                 O_HADDR,
    output logic [1:0]                  O_HTRANS,
    output logic                        O_HWRITE,
    output logic [2:0]                  O_HSIZE,
    output logic [2:0]                  O_HBURST,
    output logic [31:0]                 O_HWDATA,
    input  logic [31:0]                 I_HRDATA,
    input  logic                        I_HREADY,
    input  logic                        I_HRESP
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam logic [1:0] HT_IDLE   = 2'b00;
    localparam logic [1:0] HT_NONSEQ = 2'b10;
    localparam logic [1:0] HT_SEQ    = 2'b11;

    typedef enum logic [2:0] {S_IDLE, S_ADDR, S_BURST, S_LAST, S_ERR} state_t;

    state_t        state_q, state_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [LW-1:0] level_q, level_d;
    logic          error_q, error_d;
    logic [4:0]    remain_q, remain_d;
    logic [31:0]   haddr_q, haddr_d;
    logic [1:0]    htrans_q, htrans_d;
    logic          hwrite_q, hwrite_d;
    logic [2:0]    hsize_q, hsize_d;
    logic [2:0]    hburst_q, hburst_d;
    logic [31:0]   hwdata_q, hwdata_d;

    logic [31:0]   mem [FIFO_DEPTH];

    logic          idle, size_ok, res_ok, accept, illegal;
    logic          data_phase, bus_err, push, pop, boundary;
    logic [LW-1:0] beats_req, free_space;
    logic [31:0]   incr, next_addr;

    assign idle       = (state_q == S_IDLE);
    assign size_ok    = (I_SIZE <= 3'd2);
    assign beats_req  = LW'(I_COUNT) + LW'(1);
    assign free_space = LW'(FIFO_DEPTH) - level_q;
    assign res_ok     = I_WRITE ? (level_q >= beats_req) : (free_space >= beats_req);

    // An illegal-size request is acknowledged for one cycle so core_set can move on.
    assign O_DMA_READY = I_HRESET_N & idle & (size_ok ? res_ok : I_BUSY);
    assign accept      = I_BUSY & O_DMA_READY & size_ok;
    assign illegal     = I_BUSY & O_DMA_READY & ~size_ok;

    assign data_phase = (state_q == S_BURST) || (state_q == S_LAST);
    assign bus_err    = data_phase & I_HRESP & ~I_HREADY;
    assign push       = data_phase & I_HREADY & ~hwrite_q;
    assign pop        = data_phase & I_HREADY & hwrite_q;
    assign incr       = 32'd1 << hsize_q;
    assign next_addr  = haddr_q + incr;

`ifdef ROT_DMA_1KB_SPLIT_EN
    assign boundary = (next_addr[31:10] != haddr_q[31:10]);
`else
    assign boundary = 1'b0;
`endif

    always_comb begin
        state_d  = state_q;
        haddr_d  = haddr_q;
        htrans_d = htrans_q;
        hwrite_d = hwrite_q;
        hsize_d  = hsize_q;
        hburst_d = hburst_q;
        hwdata_d = hwdata_q;
        remain_d = remain_q;
        error_d  = error_q;
        wr_ptr_d = wr_ptr_q + AW'(push);
        rd_ptr_d = rd_ptr_q + AW'(pop);
        level_d  = level_q + LW'(push) - LW'(pop);

        if (bus_err) begin
            // First error cycle: withdraw the pending address and finish the response in S_ERR.
            state_d  = S_ERR;
            htrans_d = HT_IDLE;
            error_d  = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (accept) begin
                        state_d  = S_ADDR;
                        haddr_d  = I_ADDR;
                        htrans_d = HT_NONSEQ;
                        hwrite_d = I_WRITE;
                        hsize_d  = I_SIZE;
                        hburst_d = (I_COUNT == 5'd0) ? 3'b000 : 3'b001;
                        remain_d = I_COUNT;
                    end else if (illegal) begin
                        error_d = 1'b1;
                    end else if (I_START) begin
                        wr_ptr_d = '0;
                        rd_ptr_d = '0;
                        level_d  = '0;
                        error_d  = 1'b0;
                    end
                end
                S_ADDR, S_BURST: begin
                    if (I_HREADY) begin
                        if (remain_q != 5'd0) begin
                            state_d  = S_BURST;
                            haddr_d  = next_addr;
                            htrans_d = boundary ? HT_NONSEQ : HT_SEQ;
                            remain_d = remain_q - 5'd1;
                        end else begin
                            state_d  = S_LAST;
                            htrans_d = HT_IDLE;
                        end
                        // Next data phase begins: present the word that will be at the head after this pop.
                        if (hwrite_q) begin
                            hwdata_d = mem[rd_ptr_d];
                        end
                    end
                end
                S_LAST: begin
                    if (I_HREADY) begin
                        state_d = S_IDLE;
                    end
                end
                S_ERR: begin
                    if (I_HREADY) begin
                        state_d = S_IDLE;
                    end
                end
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (!I_HRESET_N) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            error_q  <= 1'b0;
            remain_q <= '0;
            haddr_q  <= '0;
            htrans_q <= HT_IDLE;
            hwrite_q <= 1'b0;
            hsize_q  <= '0;
            hburst_q <= '0;
            hwdata_q <= '0;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            error_q  <= error_d;
            remain_q <= remain_d;
            haddr_q  <= haddr_d;
            htrans_q <= htrans_d;
            hwrite_q <= hwrite_d;
            hsize_q  <= hsize_d;
            hburst_q <= hburst_d;
            hwdata_q <= hwdata_d;
        end
    end

    always_ff @(posedge I_HCLK) begin
        if (push) begin
            mem[wr_ptr_q] <= I_HRDATA;
        end
    end

    assign O_ERROR  = error_q;
    assign O_LEVEL  = level_q;
    assign O_HADDR  = haddr_q;
    assign O_HTRANS = htrans_q;
    assign O_HWRITE = hwrite_q;
    assign O_HSIZE  = hsize_q;
    assign O_HBURST = hburst_q;
    assign O_HWDATA = hwdata_q;

endmodule
